// File: rtl/value_index_packer.sv
// Tags each signed sample of a frame with its position index and streams the
// packed {value, index} words through a small first-word fall-through FIFO.
module value_index_packer #(
  parameter int VAL_W      = 8,
  parameter int IDX_W      = 5,
  parameter int FRAME_LEN  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VAL_W-1:0]       in_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VAL_W+IDX_W-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WORD_W = VAL_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               frame_done_q, frame_done_d;

  // Each entry holds {last, value, index}.
  logic [WORD_W:0]    mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, push_last, head_last;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign push_last = (idx_q == LAST_IDX);
  assign head_last = mem_q[rd_ptr_q][WORD_W];

  assign in_ready   = (state_q == FILL) && !full;
  assign push       = in_valid && in_ready;
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  // Gating with empty keeps out_data at zero after reset without clearing storage.
  assign out_data   = empty ? '0 : mem_q[rd_ptr_q][WORD_W-1:0];
  assign out_last   = !empty && head_last;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (push) begin
          idx_d = idx_q + IDX_W'(1);
          if (push_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: storage is not reset; pointers and count define validity, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, in_value, idx_q};
  end

endmodule

// File: tb/tb_value_index_packer.sv
// Self-checking bench for value_index_packer: a queue-based frame model checks the
// default instance every cycle, a FRAME_LEN=3 instance is checked with literals.
module tb_value_index_packer;
  localparam int VAL_W = 8, IDX_W = 5, FRAME_LEN = 32, DEPTH = 4, W = VAL_W + IDX_W;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [VAL_W-1:0] in_value = '0;
  logic             in_ready, out_valid, out_last, busy, frame_done;
  logic [W-1:0]     out_data;

  logic             s_start = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [VAL_W-1:0] s_in_value = '0;
  logic             s_in_ready, s_out_valid, s_out_last, s_busy, s_frame_done;
  logic [W-1:0]     s_out_data;

  value_index_packer #(.VAL_W(VAL_W), .IDX_W(IDX_W), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_done(frame_done));

  value_index_packer #(.VAL_W(VAL_W), .IDX_W(IDX_W), .FRAME_LEN(3), .FIFO_DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_value(s_in_value), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy), .frame_done(s_frame_done));

  int n_tests = 0, n_fail = 0;
  int n_words = 0, n_lasts = 0, n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out, got no event, expected one (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample to the default instance and hold it until accepted.
  task automatic send(input logic [VAL_W-1:0] v);
    in_valid = 1'b1;
    in_value = v;
    for (int i = 0; i < 500; i++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    timeout("send");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      if (frame_done) return;
      tick();
    end
    timeout("wait_done");
  endtask

  // Frame model: a queue of tagged words plus a phase and an index counter.
  typedef enum {M_IDLE, M_FILL, M_DRAIN} mmode_e;
  typedef struct {
    logic [VAL_W-1:0] val;
    logic [IDX_W-1:0] idx;
    bit               last;
  } word_t;

  word_t  m_q[$];
  mmode_e m_mode = M_IDLE;
  int     m_idx  = 0;
  bit     m_fd   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_mode = M_IDLE;
      m_idx  = 0;
      m_fd   = 1'b0;
    end else begin
      bit    acc, take, was_last;
      word_t w;
      acc      = (m_mode == M_FILL) && (m_q.size() < DEPTH) && in_valid;
      take     = (m_q.size() > 0) && out_ready;
      was_last = 1'b0;
      m_fd     = 1'b0;
      if (take) begin
        w        = m_q.pop_front();
        was_last = w.last;
      end
      case (m_mode)
        M_IDLE: if (start) begin
          m_mode = M_FILL;
          m_idx  = 0;
        end
        M_FILL: if (acc) begin
          w.val  = in_value;
          w.idx  = IDX_W'(m_idx);
          w.last = (m_idx == FRAME_LEN - 1);
          m_q.push_back(w);
          if (w.last) m_mode = M_DRAIN;
          m_idx++;
        end
        M_DRAIN: if (was_last) begin
          m_mode = M_IDLE;
          m_fd   = 1'b1;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Compare the default instance against the model away from the active edge.
  always @(negedge clk) begin
    check("cyc.in_ready",   in_ready,   (m_mode == M_FILL) && (m_q.size() < DEPTH));
    check("cyc.out_valid",  out_valid,  m_q.size() > 0);
    check("cyc.busy",       busy,       m_mode != M_IDLE);
    check("cyc.frame_done", frame_done, m_fd);
    if (m_q.size() > 0) begin
      check("cyc.out_data", out_data, {m_q[0].val, m_q[0].idx});
      check("cyc.out_last", out_last, m_q[0].last);
    end
    if (out_valid && out_ready) begin
      n_words++;
      if (out_last) n_lasts++;
    end
    if (frame_done) n_done++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  bit rand_done = 1'b0;
  int done_snap;

  initial begin
    // Reset state.
    repeat (2) tick();
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_data", out_data, 0);
    check("rst.busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // 1: reset mid-FILL after three accepted samples.
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    send(8'd1); send(8'd2); send(8'd3);
    check("t1.pre_valid", out_valid, 1);
    done_snap = n_done;
    #2 rst_n = 1'b0;
    #1;
    check("t1.out_valid", out_valid, 0);
    check("t1.out_data", out_data, 0);
    check("t1.out_last", out_last, 0);
    check("t1.busy", busy, 0);
    check("t1.in_ready", in_ready, 0);
    check("t1.frame_done", frame_done, 0);
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check("t1.after_valid", out_valid, 0);
    check("t1.after_busy", busy, 0);
    check("t1.no_done", n_done, done_snap);

    // 2: full frame -16..15, downstream always ready.
    out_ready = 1'b1;
    n_words = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int v = -16; v <= 15; v++) begin
      send(VAL_W'(v));
      if (v == -16) check("t2.first_word", out_data, 13'h1E00);
    end
    check("t2.last_word", out_data, 13'h01FF);
    check("t2.last_flag", out_last, 1);
    check("t2.drain_ready", in_ready, 0);
    tick();
    check("t2.frame_done", frame_done, 1);
    check("t2.idle", busy, 0);
    check("t2.word_count", n_words, 32);
    tick();
    check("t2.done_pulse", frame_done, 0);

    // 3: downstream stalled during FILL.
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_value = VAL_W'(-16 + i);
      check("t3.accept", in_ready, 1);
      tick();
    end
    in_value = VAL_W'(-12);
    for (int i = 0; i < 3; i++) begin
      check("t3.full_block", in_ready, 0);
      check("t3.stable", out_data, 13'h1E00);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t3.ready_back", in_ready, 1);
    check("t3.second_word", out_data, 13'h1E21);
    in_valid = 1'b0;
    for (int v = -12; v <= 15; v++) send(VAL_W'(v));
    wait_done();
    tick();

    // 5: start ignored in FILL and DRAIN, honoured alongside frame_done.
    start = 1'b1; tick(); start = 1'b0;
    send(8'd0); send(8'd1);
    start = 1'b1;
    send(8'd2);
    check("t5.idx_fill", out_data, {8'd2, 5'd2});
    for (int v = 3; v <= 31; v++) send(VAL_W'(v));
    out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("t5.drain_busy", busy, 1);
    check("t5.drain_word", out_data, 13'h03FF);
    out_ready = 1'b1;
    wait_done();
    check("t5.done_seen", frame_done, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("t5.restart_busy", busy, 1);
    send(8'd7);
    check("t5.restart_idx0", out_data, 13'h00E0);
    for (int v = 1; v <= 31; v++) send(VAL_W'(v));
    wait_done();

    // 4: three-sample frame on the second instance.
    s_out_ready = 1'b0;
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("t4.busy", s_busy, 1);
    s_in_valid = 1'b1;
    s_in_value = 8'd5;   check("t4.ready0", s_in_ready, 1); tick();
    s_in_value = 8'hFF;  tick();
    s_in_value = 8'd127; tick();
    s_in_value = 8'd9;
    check("t4.drain_ready", s_in_ready, 0);
    check("t4.w0", s_out_data, 13'h00A0);
    check("t4.l0", s_out_last, 0);
    s_out_ready = 1'b1;
    tick();
    check("t4.w1", s_out_data, 13'h1FE1);
    check("t4.l1", s_out_last, 0);
    tick();
    check("t4.w2", s_out_data, 13'h0FE2);
    check("t4.l2", s_out_last, 1);
    tick();
    check("t4.frame_done", s_frame_done, 1);
    check("t4.no_fourth", s_out_valid, 0);
    s_in_valid = 1'b0;
    tick();
    check("t4.done_pulse", s_frame_done, 0);
    check("t4.idle", s_busy, 0);

    // 6: random valid/ready over ten frames.
    tick();
    n_lasts = 0;
    done_snap = n_done;
    fork
      begin
        while (!rand_done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join_none
    for (int f = 0; f < 10; f++) begin
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < FRAME_LEN; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(VAL_W'($urandom));
      end
      wait_done();
    end
    rand_done = 1'b1;
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    check("t6.lasts", n_lasts, 10);
    check("t6.dones", n_done - done_snap, 10);
    check("t6.idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
